// File: rtl/if_stage_pkg.sv
// Shared MiniMIPS32 fetch-stage definitions: bus widths, stall encoding,
// exception codes, reset PC and the next-PC source selector.
package if_stage_pkg;

    localparam int STALL_BUS     = 4;
    localparam int INST_ADDR_BUS = 32;
    localparam int EXC_CODE_BUS  = 5;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [EXC_CODE_BUS-1:0]  EXC_NONE = 5'h10;
    localparam logic [EXC_CODE_BUS-1:0]  EXC_ADEL = 5'h04;
    localparam logic [INST_ADDR_BUS-1:0] PC_INIT  = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        SEL_FLUSH,
        SEL_HOLD,
        SEL_JUMP,
        SEL_PEND,
        SEL_SEQ
    } pc_sel_e;

    function automatic logic [INST_ADDR_BUS-1:0] pc_inc(input logic [INST_ADDR_BUS-1:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/if_redirect_hold.sv
// Holds a branch/jump redirect that arrives while the PC is stalled and
// releases it on the first unstalled update; flush or a live jump discards it.
module if_redirect_hold
    import if_stage_pkg::*;
(
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst,
    input  logic                     ce,
    input  logic                     flush,
    input  logic                     stop,
    input  logic                     jump_en,
    input  logic [INST_ADDR_BUS-1:0] jump_addr,
    output logic                     pend_valid,
    output logic [INST_ADDR_BUS-1:0] pend_addr
);

    logic                     pend_q;
    logic [INST_ADDR_BUS-1:0] pend_addr_q;

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else if (ce) begin
            if (flush) begin
                pend_q <= 1'b0;
            end else if (stop) begin
                // Latest jump during a stall wins
                if (jump_en) begin
                    pend_q      <= 1'b1;
                    pend_addr_q <= jump_addr;
                end
            end else begin
                pend_q <= 1'b0;
            end
        end
    end

    assign pend_valid = pend_q;
    assign pend_addr  = pend_addr_q;

endmodule

// File: rtl/if_stage.sv
// MiniMIPS32 instruction-fetch stage: PC register, next-PC selection and
// instruction-memory request. Optional misaligned-PC check: IF_ADDR_CHECK_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [INST_ADDR_BUS-1:0] PC_INIT_VAL = PC_INIT
) (
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst,
    input  logic [STALL_BUS-1:0]     stall,
    input  logic                     flush,
    input  logic [INST_ADDR_BUS-1:0] cp0_excaddr,
    input  logic                     jump_en,
    input  logic [INST_ADDR_BUS-1:0] jump_addr,
    output logic [INST_ADDR_BUS-1:0] pc,
    output logic [INST_ADDR_BUS-1:0] pc_plus_4,
    output logic [EXC_CODE_BUS-1:0]  exccode,
    output logic                     ice,
    output logic [INST_ADDR_BUS-1:0] iaddr
);

    logic [INST_ADDR_BUS-1:0] pc_q;
    logic [INST_ADDR_BUS-1:0] pc_next;
    logic                     ce_q;
    logic                     pend_valid;
    logic [INST_ADDR_BUS-1:0] pend_addr;
    pc_sel_e                  pc_sel;
    logic                     unused_stall;

    assign unused_stall = ^stall[STALL_BUS-1:1];

    if_redirect_hold u_redirect_hold (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .ce          (ce_q),
        .flush       (flush),
        .stop        (stall[0] == STOP),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .pend_valid  (pend_valid),
        .pend_addr   (pend_addr)
    );

    always_comb begin
        pc_sel = SEL_SEQ;
        if (flush)                 pc_sel = SEL_FLUSH;
        else if (stall[0] == STOP) pc_sel = SEL_HOLD;
        else if (jump_en)          pc_sel = SEL_JUMP;
        else if (pend_valid)       pc_sel = SEL_PEND;
    end

    always_comb begin
        pc_next = pc_inc(pc_q);
        case (pc_sel)
            SEL_FLUSH: pc_next = cp0_excaddr;
            SEL_HOLD:  pc_next = pc_q;
            SEL_JUMP:  pc_next = jump_addr;
            SEL_PEND:  pc_next = pend_addr;
            default:   pc_next = pc_inc(pc_q);
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            pc_q <= PC_INIT_VAL;
            ce_q <= 1'b0;
        end else begin
            ce_q <= 1'b1;
            if (ce_q) begin
                pc_q <= pc_next;
            end
        end
    end

    assign pc        = pc_q;
    assign iaddr     = pc_q;
    assign pc_plus_4 = pc_inc(pc_q);

`ifdef IF_ADDR_CHECK_EN
    logic misaligned;
    assign misaligned = |pc_q[1:0];
    assign exccode    = (ce_q && misaligned) ? EXC_ADEL : EXC_NONE;
    assign ice        = ce_q & ~misaligned;
`else
    assign exccode = EXC_NONE;
    assign ice     = ce_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: reset, jump, held redirect, flush
// priority, misaligned fetch and 32-bit PC wrap.
module tb_if_stage;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst;
    logic [3:0]  stall;
    logic        flush;
    logic [31:0] cp0_excaddr;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [4:0]  exccode;
    logic        ice;
    logic [31:0] iaddr;

    int vectors = 0;
    int miscompares = 0;

    if_stage dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .stall       (stall),
        .flush       (flush),
        .cp0_excaddr (cp0_excaddr),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .pc          (pc),
        .pc_plus_4   (pc_plus_4),
        .exccode     (exccode),
        .ice         (ice),
        .iaddr       (iaddr)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
        $display("t=%0t rst=%b stall=%b flush=%b jump=%b pc=%h pc4=%h ice=%b exc=%h",
                 $time, cpu_rst, stall, flush, jump_en, pc, pc_plus_4, ice, exccode);
    endtask

    task automatic idle_inputs();
        stall = 4'b0000; flush = 1'b0; cp0_excaddr = '0; jump_en = 1'b0; jump_addr = '0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        cpu_rst = 1'b1;
        idle_inputs();
        tick();
        vectors++;
        if (ice !== 1'b0 || pc !== 32'hBFC0_0000 || exccode !== 5'h10) begin
            miscompares++;
            $display("FAIL reset_c1: ice=%b pc=%h exc=%h want ice=0 pc=bfc00000 exc=10", ice, pc, exccode);
        end
        tick();
        cpu_rst = 1'b0;
        vectors++;
        if (ice !== 1'b0 || iaddr !== 32'hBFC0_0000) begin
            miscompares++;
            $display("FAIL reset_c2: ice=%b iaddr=%h want ice=0 iaddr=bfc00000", ice, iaddr);
        end
        exp_pc = 32'hBFC0_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (ice !== 1'b1 || pc !== exp_pc || pc_plus_4 !== exp_pc + 32'd4 || iaddr !== exp_pc) begin
                miscompares++;
                $display("FAIL reset_seq%0d: ice=%b pc=%h pc4=%h iaddr=%h want ice=1 pc=%h pc4=%h",
                         i, ice, pc, pc_plus_4, iaddr, exp_pc, exp_pc + 32'd4);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_jump();
        jump_en = 1'b1; jump_addr = 32'h8000_0100;
        tick();
        jump_en = 1'b0;
        vectors++;
        if (pc !== 32'h8000_0100) begin
            miscompares++;
            $display("FAIL jump_target: pc=%h want 80000100", pc);
        end
        tick();
        vectors++;
        if (pc !== 32'h8000_0104 || pc_plus_4 !== 32'h8000_0108) begin
            miscompares++;
            $display("FAIL jump_next: pc=%h pc4=%h want 80000104/80000108", pc, pc_plus_4);
        end
    endtask

    task automatic test_held_redirect();
        stall = 4'b0011; jump_en = 1'b1; jump_addr = 32'h8000_0200;
        for (int i = 0; i < 3; i++) begin
            tick();
            jump_en = 1'b0;
            vectors++;
            if (pc !== 32'h8000_0104) begin
                miscompares++;
                $display("FAIL held_stall%0d: pc=%h want 80000104", i, pc);
            end
        end
        stall = 4'b0000;
        tick();
        vectors++;
        if (pc !== 32'h8000_0200) begin
            miscompares++;
            $display("FAIL held_release: pc=%h want 80000200", pc);
        end
        tick();
        vectors++;
        if (pc !== 32'h8000_0204) begin
            miscompares++;
            $display("FAIL held_after: pc=%h want 80000204", pc);
        end
        // two jumps in one stall: the later target is the one taken
        stall = 4'b0001; jump_en = 1'b1; jump_addr = 32'h8000_0300;
        tick();
        jump_addr = 32'h8000_0400;
        tick();
        jump_en = 1'b0; stall = 4'b0000;
        tick();
        vectors++;
        if (pc !== 32'h8000_0400) begin
            miscompares++;
            $display("FAIL held_latest: pc=%h want 80000400", pc);
        end
        // live jump on release overrides the stale pending target
        stall = 4'b0001; jump_en = 1'b1; jump_addr = 32'h8000_0500;
        tick();
        stall = 4'b0000; jump_addr = 32'h8000_0600;
        tick();
        jump_en = 1'b0;
        vectors++;
        if (pc !== 32'h8000_0600) begin
            miscompares++;
            $display("FAIL live_over_pend: pc=%h want 80000600", pc);
        end
        tick();
        vectors++;
        if (pc !== 32'h8000_0604) begin
            miscompares++;
            $display("FAIL live_over_pend_next: pc=%h want 80000604", pc);
        end
    endtask

    task automatic test_flush_priority();
        stall = 4'b0001; jump_en = 1'b1; jump_addr = 32'h8000_0700;
        tick();
        flush = 1'b1; cp0_excaddr = 32'hBFC0_0380; jump_addr = 32'h8000_0800;
        tick();
        flush = 1'b0; jump_en = 1'b0;
        vectors++;
        if (pc !== 32'hBFC0_0380) begin
            miscompares++;
            $display("FAIL flush_target: pc=%h want bfc00380", pc);
        end
        stall = 4'b0000;
        tick();
        vectors++;
        if (pc !== 32'hBFC0_0384) begin
            miscompares++;
            $display("FAIL flush_clears_pend: pc=%h want bfc00384", pc);
        end
    endtask

    task automatic test_misaligned();
        jump_en = 1'b1; jump_addr = 32'h8000_0102;
        tick();
        jump_en = 1'b0;
        vectors++;
        if (pc !== 32'h8000_0102 || pc_plus_4 !== 32'h8000_0106) begin
            miscompares++;
            $display("FAIL misalign_pc: pc=%h pc4=%h want 80000102/80000106", pc, pc_plus_4);
        end
`ifdef IF_ADDR_CHECK_EN
        vectors++;
        if (exccode !== 5'h04 || ice !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_exc: exc=%h ice=%b want 04/0", exccode, ice);
        end
`else
        vectors++;
        if (exccode !== 5'h10 || ice !== 1'b1 || iaddr !== 32'h8000_0102) begin
            miscompares++;
            $display("FAIL misalign_exc: exc=%h ice=%b iaddr=%h want 10/1/80000102", exccode, ice, iaddr);
        end
`endif
    endtask

    task automatic test_wrap();
        jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
        tick();
        jump_en = 1'b0;
        vectors++;
        if (pc !== 32'hFFFF_FFFC || pc_plus_4 !== 32'h0000_0000 || exccode !== 5'h10 || ice !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_top: pc=%h pc4=%h exc=%h ice=%b want fffffffc/0/10/1", pc, pc_plus_4, exccode, ice);
        end
        tick();
        vectors++;
        if (pc !== 32'h0000_0000 || exccode !== 5'h10 || ice !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_zero: pc=%h exc=%h ice=%b want 0/10/1", pc, exccode, ice);
        end
    endtask

    task automatic test_reset_mid();
        stall = 4'b0001; jump_en = 1'b1; jump_addr = 32'h8000_0900;
        tick();
        jump_en = 1'b0; stall = 4'b0000; cpu_rst = 1'b1;
        tick();
        vectors++;
        if (pc !== 32'hBFC0_0000 || ice !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state: pc=%h ice=%b want bfc00000/0", pc, ice);
        end
        cpu_rst = 1'b0;
        tick();
        tick();
        vectors++;
        if (pc !== 32'hBFC0_0004 || ice !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_no_pend: pc=%h ice=%b want bfc00004/1", pc, ice);
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_held_redirect();
        test_flush_priority();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
